// File: rtl/uart_pkg.sv
// Shared UART definitions: default line timing, command bytes understood by the
// receiver, and the transmitter state encoding.
package uart_pkg;

    localparam int CLK_FREQ_HZ  = 25_000_000;
    localparam int BAUD_RATE    = 115_200;
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    localparam logic [7:0] CMD_TRIANGLE = 8'h54;  // 'T'
    localparam logic [7:0] CMD_SAWTOOTH = 8'h53;  // 'S'

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a look-ahead head (dout shows the oldest entry
// without popping). Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small input FIFO. Frames are sent back to back
// with no idle gap while bytes remain queued; tx is driven straight from a flop.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = CLK_FREQ_HZ,
    parameter int BAUD         = BAUD_RATE,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_d;
    logic          bit_end;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;

    assign fifo_push = tx_valid && tx_ready;
    assign tx_ready  = !fifo_full;
    assign tx_busy   = (state_q != IDLE) || !fifo_empty;
    assign bit_end   = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx        <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx        <= tx_d;
        end
    end

    // tx_d is the line level for the cycle after this edge, so every state
    // transition also decides the first level of the bit it enters.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx;
        fifo_pop  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: default 217-clock instance plus a
// 4-clock, depth-2 instance; frames decoded from tx are scored against a queue.
module tb_uart_transmitter;

    localparam int CPB  = 25_000_000 / 115_200;
    localparam int CPB2 = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data,  tx_data2;
    logic       tx_valid, tx_valid2;
    logic       tx_ready, tx_ready2;
    logic       tx,       tx2;
    logic       tx_busy,  tx_busy2;

    logic [7:0] exp_q[$];
    logic [7:0] exp_q2[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         rst_gen    = 0;

    uart_transmitter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    uart_transmitter #(
        .CLKS_PER_BIT (CPB2),
        .FIFO_DEPTH   (2)
    ) dut_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data2),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready2),
        .tx       (tx2),
        .tx_busy  (tx_busy2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #(40 * 100_000);
        $display("FAIL watchdog: observed no finish, expected finish within 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Frame decoders: sample mid-bit on falling clock edges after a start edge.
    logic [7:0]  m_byte,  m_byte2;
    logic        m_start, m_stop, m_start2, m_stop2;
    int          m_gen,   m_gen2;
    logic [31:0] m_exp,   m_exp2;

    always begin
        @(negedge tx);
        m_gen = rst_gen;
        repeat (CPB / 2) @(negedge clk);
        m_start = tx;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            m_byte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        m_stop = tx;
        if (m_gen == rst_gen) begin
            m_exp = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hxxxx_xxxx;
            check("start_bit", {31'h0, m_start}, 32'h0);
            check("frame_byte", {24'h0, m_byte}, m_exp);
            check("stop_bit", {31'h0, m_stop}, 32'h1);
        end
    end

    always begin
        @(negedge tx2);
        m_gen2 = rst_gen;
        repeat (CPB2 / 2) @(negedge clk);
        m_start2 = tx2;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB2) @(negedge clk);
            m_byte2[i] = tx2;
        end
        repeat (CPB2) @(negedge clk);
        m_stop2 = tx2;
        if (m_gen2 == rst_gen) begin
            m_exp2 = (exp_q2.size() > 0) ? {24'h0, exp_q2.pop_front()} : 32'hxxxx_xxxx;
            check("small_start_bit", {31'h0, m_start2}, 32'h0);
            check("small_frame_byte", {24'h0, m_byte2}, m_exp2);
            check("small_stop_bit", {31'h0, m_stop2}, 32'h1);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic push_byte(input logic [7:0] b, output int waited);
        waited   = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && waited < 30_000) begin
            @(negedge clk);
            waited++;
        end
        if (tx_ready) exp_q.push_back(b);
        check("push_accept", {31'h0, tx_ready}, 32'h1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic push_small(input logic [7:0] b);
        int waited = 0;
        tx_data2  = b;
        tx_valid2 = 1'b1;
        while (!tx_ready2 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (tx_ready2) exp_q2.push_back(b);
        check("small_push_accept", {31'h0, tx_ready2}, 32'h1);
        @(negedge clk);
        tx_valid2 = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((tx_busy || tx_busy2) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {30'h0, tx_busy, tx_busy2}, 32'h0);
        repeat (5) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int waited;
        logic all_tx, all_busy, all_ready;

        rst_n     = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_data2  = 8'h00;
        tx_valid2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'h0, tx}, 32'h1);
        check("reset_ready", {31'h0, tx_ready}, 32'h1);
        check("reset_busy", {31'h0, tx_busy}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte: tx falls one edge after the accept, frame lasts 10 bits.
        push_byte(8'h54, waited);
        check("lat_edge_n_tx", {31'h0, tx}, 32'h1);
        check("lat_edge_n_busy", {31'h0, tx_busy}, 32'h1);
        @(negedge clk);
        check("lat_edge_n1_tx", {31'h0, tx}, 32'h0);
        n = 0;
        while (tx_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("frame_len", n, 32'(10 * CPB));
        repeat (5) @(negedge clk);

        // Back-to-back: stop bit is exactly one bit time, then the next start.
        push_byte(8'h54, waited);
        push_byte(8'h53, waited);
        repeat (9 * CPB - 1) @(negedge clk);
        check("b2b_bit7", {31'h0, tx}, 32'h0);
        @(negedge clk);
        check("b2b_stop_begin", {31'h0, tx}, 32'h1);
        repeat (CPB - 1) @(negedge clk);
        check("b2b_stop_end", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("b2b_second_start", {31'h0, tx}, 32'h0);
        wait_idle("b2b_idle", 5000);

        // Backpressure: one byte in flight plus four queued fills the FIFO.
        for (int i = 1; i <= 5; i++) push_byte(8'(i), waited);
        check("bp_ready_low", {31'h0, tx_ready}, 32'h0);
        push_byte(8'h06, waited);
        check("bp_wait", waited, 32'(10 * CPB - 3));
        wait_idle("bp_idle", 6 * 10 * CPB + 100);
        check("bp_all_seen", exp_q.size(), 32'h0);

        // Reset during data bit 3 with two bytes queued.
        push_byte(8'hA5, waited);
        push_byte(8'h11, waited);
        push_byte(8'h22, waited);
        repeat (4 * CPB + 100) @(negedge clk);
        rst_gen++;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", {31'h0, tx}, 32'h1);
        check("rst_mid_busy", {31'h0, tx_busy}, 32'h0);
        check("rst_mid_ready", {31'h0, tx_ready}, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        all_tx = 1'b1;
        all_busy = 1'b0;
        all_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            all_tx    = all_tx & tx;
            all_busy  = all_busy | tx_busy;
            all_ready = all_ready & tx_ready;
        end
        check("post_rst_tx_high", {31'h0, all_tx}, 32'h1);
        check("post_rst_busy_low", {31'h0, all_busy}, 32'h0);
        check("post_rst_ready_high", {31'h0, all_ready}, 32'h1);

        // Small instance: 4 clocks per bit, two-entry FIFO.
        push_small(8'h96);
        check("small_lat_n_tx", {31'h0, tx2}, 32'h1);
        @(negedge clk);
        check("small_lat_n1_tx", {31'h0, tx2}, 32'h0);
        n = 0;
        while (tx_busy2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("small_frame_len", n, 32'(10 * CPB2));
        repeat (5) @(negedge clk);
        push_small(8'hC3);
        push_small(8'h3C);
        push_small(8'h81);
        check("small_full", {31'h0, tx_ready2}, 32'h0);
        wait_idle("small_idle", 500);
        check("small_all_seen", exp_q2.size(), 32'h0);
        check("main_all_seen", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
